wb_arbiter2: RTL

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter with locked block transfers; optional watchdog when WB_ARB_TIMEOUT_EN is defined
module wb_arbiter2 #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   // master 0: GPMC bridge
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [DATA_WIDTH-1:0] m0_writedata,
   input  logic                  m0_write,
   input  logic                  m0_strobe,
   input  logic                  m0_cycle,
   output logic [DATA_WIDTH-1:0] m0_readdata,
   output logic                  m0_ack,
   // master 1: on-chip sequencer
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [DATA_WIDTH-1:0] m1_writedata,
   input  logic                  m1_write,
   input  logic                  m1_strobe,
   input  logic                  m1_cycle,
   output logic [DATA_WIDTH-1:0] m1_readdata,
   output logic                  m1_ack,
   // shared bus toward the intercon
   output logic [ADDR_WIDTH-1:0] s_address,
   output logic [DATA_WIDTH-1:0] s_writedata,
   output logic                  s_write,
   output logic                  s_strobe,
   output logic                  s_cycle,
   input  logic [DATA_WIDTH-1:0] s_readdata,
   input  logic                  s_ack,
   // status
   output logic [1:0]            grant,
   output logic                  timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Word returned to a master whose transfer was aborted by the watchdog.
   localparam logic [DATA_WIDTH-1:0] ABORT_WORD = DATA_WIDTH'(16'hDEAD);

   state_t     state_q, state_d;
   logic       last_q, last_d;   // 1: master 1 was served last, so master 0 wins a tie
   logic [1:0] grant_q, grant_d;
   logic       abort;            // watchdog expiry cycle: answer the owner and release the bus

   // Arbitration rule shared by IDLE and by the handoff out of an owner state.
   function automatic state_t pick(input logic c0, input logic c1, input logic last1);
      state_t r;
      r = IDLE;
      if (c0 && !c1)      r = OWN0;
      else if (c1 && !c0) r = OWN1;
      else if (c0 && c1)  r = last1 ? OWN0 : OWN1;
      return r;
   endfunction

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign abort = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Count stalled strobe cycles of the current owner; any ack or ownership change restarts it.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (s_ack)
         cnt_d = '0;
      else if ((state_q != IDLE) && s_strobe)
         cnt_d = cnt_q + 1'b1;
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign abort = 1'b0;
`endif

   // Next owner: hold while the owner's cycle is high, otherwise re-arbitrate on the same edge.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE:    state_d = pick(m0_cycle, m1_cycle, last_q);
         OWN0:    if (!m0_cycle) state_d = pick(1'b0, m1_cycle, last_q);
         OWN1:    if (!m1_cycle) state_d = pick(m0_cycle, 1'b0, last_q);
         default: state_d = IDLE;
      endcase
      if (abort)
         state_d = IDLE;
      if ((state_d == OWN0) && (state_q != OWN0))
         last_d = 1'b0;
      else if ((state_d == OWN1) && (state_q != OWN1))
         last_d = 1'b1;
      case (state_d)
         OWN0:    grant_d = 2'b01;
         OWN1:    grant_d = 2'b10;
         default: grant_d = 2'b00;
      endcase
   end

   // Arbiter FSM with registered grant and last-owner bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

   assign grant   = grant_q;
   assign timeout = abort;

   // Bus steering: the owner is wired straight through, everyone else sees zeros.
   always_comb begin
      s_address   = '0;
      s_writedata = '0;
      s_write     = 1'b0;
      s_strobe    = 1'b0;
      s_cycle     = 1'b0;
      m0_readdata = '0;
      m0_ack      = 1'b0;
      m1_readdata = '0;
      m1_ack      = 1'b0;
      case (state_q)
         OWN0: begin
            if (abort) begin
               m0_ack      = 1'b1;
               m0_readdata = ABORT_WORD;
            end else begin
               s_address   = m0_address;
               s_writedata = m0_writedata;
               s_write     = m0_write;
               s_strobe    = m0_strobe;
               s_cycle     = m0_cycle;
               m0_ack      = s_ack;
               m0_readdata = s_readdata;
            end
         end
         OWN1: begin
            if (abort) begin
               m1_ack      = 1'b1;
               m1_readdata = ABORT_WORD;
            end else begin
               s_address   = m1_address;
               s_writedata = m1_writedata;
               s_write     = m1_write;
               s_strobe    = m1_strobe;
               s_cycle     = m1_cycle;
               m1_ack      = s_ack;
               m1_readdata = s_readdata;
            end
         end
         default: ;
      endcase
   end

endmodule
